// File: rtl/axi_lite_ctrl_regs_if.sv
// -----------------------------------------------------------------------------
// axi_lite_ctrl_regs_if
// AXI4-Lite bus-A signal bundle between a bus master and the control-register
// slave. Clock and reset are plain ports on the modules.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width (32 or 64)
//
// Channels: AW (addr/valid/ready), W (data/strb/valid/ready),
//           B (resp/valid/ready), AR (addr/valid/ready),
//           R (data/resp/valid/ready).
// Modports: master drives requests, slave drives responses.
// -----------------------------------------------------------------------------
interface axi_lite_ctrl_regs_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   s_axi_BUS_A_AWADDR;
    logic                s_axi_BUS_A_AWVALID;
    logic                s_axi_BUS_A_AWREADY;
    logic [DATA_W-1:0]   s_axi_BUS_A_WDATA;
    logic [DATA_W/8-1:0] s_axi_BUS_A_WSTRB;
    logic                s_axi_BUS_A_WVALID;
    logic                s_axi_BUS_A_WREADY;
    logic [1:0]          s_axi_BUS_A_BRESP;
    logic                s_axi_BUS_A_BVALID;
    logic                s_axi_BUS_A_BREADY;
    logic [ADDR_W-1:0]   s_axi_BUS_A_ARADDR;
    logic                s_axi_BUS_A_ARVALID;
    logic                s_axi_BUS_A_ARREADY;
    logic [DATA_W-1:0]   s_axi_BUS_A_RDATA;
    logic [1:0]          s_axi_BUS_A_RRESP;
    logic                s_axi_BUS_A_RVALID;
    logic                s_axi_BUS_A_RREADY;

    modport master (
        output s_axi_BUS_A_AWADDR, s_axi_BUS_A_AWVALID,
        input  s_axi_BUS_A_AWREADY,
        output s_axi_BUS_A_WDATA, s_axi_BUS_A_WSTRB, s_axi_BUS_A_WVALID,
        input  s_axi_BUS_A_WREADY,
        input  s_axi_BUS_A_BRESP, s_axi_BUS_A_BVALID,
        output s_axi_BUS_A_BREADY,
        output s_axi_BUS_A_ARADDR, s_axi_BUS_A_ARVALID,
        input  s_axi_BUS_A_ARREADY,
        input  s_axi_BUS_A_RDATA, s_axi_BUS_A_RRESP, s_axi_BUS_A_RVALID,
        output s_axi_BUS_A_RREADY
    );

    modport slave (
        input  s_axi_BUS_A_AWADDR, s_axi_BUS_A_AWVALID,
        output s_axi_BUS_A_AWREADY,
        input  s_axi_BUS_A_WDATA, s_axi_BUS_A_WSTRB, s_axi_BUS_A_WVALID,
        output s_axi_BUS_A_WREADY,
        output s_axi_BUS_A_BRESP, s_axi_BUS_A_BVALID,
        input  s_axi_BUS_A_BREADY,
        input  s_axi_BUS_A_ARADDR, s_axi_BUS_A_ARVALID,
        output s_axi_BUS_A_ARREADY,
        output s_axi_BUS_A_RDATA, s_axi_BUS_A_RRESP, s_axi_BUS_A_RVALID,
        input  s_axi_BUS_A_RREADY
    );
endinterface

// File: rtl/axi_lite_ctrl_regs.sv
// -----------------------------------------------------------------------------
// axi_lite_ctrl_regs
// AXI4-Lite slave control block for an accelerator core: ap_start/done/idle/
// ready handshake with optional auto-restart, N_ARGS argument registers and a
// small interrupt controller (GIE / IER / toggle-on-write ISR).
//
// Register map (index = address >> log2(DATA_WIDTH/8)):
//   0 CTRL : b0 ap_start (W1S), b1 done (COR), b2 idle (live), b3 ready (COR),
//            b7 auto_restart
//   1 GIE  : b0
//   2 IER  : b0 done source, b1 ready source
//   3 ISR  : b[1:0], write 1 toggles
//   4+i    : ARG i
//   other  : SLVERR, reads return 0
//
// Ports:
//   s_axi_BUS_A_ACLK     clock, rising edge
//   s_axi_BUS_A_ARESETN  asynchronous active-low reset
//   bus                  AXI4-Lite slave modport (axi_lite_ctrl_regs_if)
//   ap_start             start request to core
//   ap_done / ap_ready   one-cycle pulses from core
//   ap_idle              core idle level
//   args                 argument i at [i*DATA_WIDTH +: DATA_WIDTH]
//   interrupt            registered active-high interrupt
//
// Build option: define AXI_CTRL_WSTRB_EN to make WSTRB gate byte lanes on all
// writable registers; without it every write updates the full word.
// -----------------------------------------------------------------------------
module axi_lite_ctrl_regs #(
    parameter int C_S_AXI_BUS_A_ADDR_WIDTH = 32,
    parameter int C_S_AXI_BUS_A_DATA_WIDTH = 32,
    parameter int N_ARGS                   = 4
) (
    input  logic                                  s_axi_BUS_A_ACLK,
    input  logic                                  s_axi_BUS_A_ARESETN,
    axi_lite_ctrl_regs_if.slave                   bus,
    output logic                                  ap_start,
    input  logic                                  ap_done,
    input  logic                                  ap_idle,
    input  logic                                  ap_ready,
    output logic [N_ARGS*C_S_AXI_BUS_A_DATA_WIDTH-1:0] args,
    output logic                                  interrupt
);
    localparam int AW       = C_S_AXI_BUS_A_ADDR_WIDTH;
    localparam int DW       = C_S_AXI_BUS_A_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int IDX_W    = AW - ADDR_LSB;
    localparam logic [IDX_W-1:0] NREG = IDX_W'(4 + N_ARGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_CTRL_WSTRB_EN
    localparam logic STRB_EN = 1'b1;
`else
    localparam logic STRB_EN = 1'b0;
`endif

    // Byte-lane write mask; all ones when strobes are not honoured.
    function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] strb);
        logic [DW-1:0] m;
        for (int b = 0; b < SW; b++) begin
            m[b*8 +: 8] = {8{strb[b] | ~STRB_EN}};
        end
        return m;
    endfunction

    typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_e;
    typedef enum logic       {RIDLE, RDATA}        rstate_e;

    wstate_e           wstate_q, wstate_d;
    rstate_e           rstate_q, rstate_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              auto_q, auto_d;
    logic              gie_q, gie_d;
    logic [1:0]        ier_q, ier_d;
    logic [1:0]        isr_q, isr_d;
    logic              irq_q, irq_d;
    logic [DW-1:0]     arg_q [N_ARGS];
    logic [DW-1:0]     arg_d [N_ARGS];

    logic              w_commit;
    logic              ar_hs;
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  ridx;
    logic [DW-1:0]     wmask;
    logic [DW-1:0]     wnew;
    logic [DW-1:0]     rd_val;
    logic              rd_mapped;

    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^{waddr_q[ADDR_LSB-1:0], bus.s_axi_BUS_A_ARADDR[ADDR_LSB-1:0]};

    assign widx  = waddr_q[AW-1:ADDR_LSB];
    assign ridx  = bus.s_axi_BUS_A_ARADDR[AW-1:ADDR_LSB];
    assign wmask = strb_mask(bus.s_axi_BUS_A_WSTRB);
    assign wnew  = bus.s_axi_BUS_A_WDATA & wmask;

    // Write channel FSM
    always_comb begin
        wstate_d                 = wstate_q;
        waddr_d                  = waddr_q;
        bresp_d                  = bresp_q;
        w_commit                 = 1'b0;
        bus.s_axi_BUS_A_AWREADY  = 1'b0;
        bus.s_axi_BUS_A_WREADY   = 1'b0;
        bus.s_axi_BUS_A_BVALID   = 1'b0;
        case (wstate_q)
            WIDLE: begin
                bus.s_axi_BUS_A_AWREADY = 1'b1;
                if (bus.s_axi_BUS_A_AWVALID) begin
                    waddr_d  = bus.s_axi_BUS_A_AWADDR;
                    wstate_d = WDATA;
                end
            end
            WDATA: begin
                bus.s_axi_BUS_A_WREADY = 1'b1;
                if (bus.s_axi_BUS_A_WVALID) begin
                    w_commit = 1'b1;
                    bresp_d  = (widx < NREG) ? RESP_OKAY : RESP_SLVERR;
                    wstate_d = WRESP;
                end
            end
            WRESP: begin
                bus.s_axi_BUS_A_BVALID = 1'b1;
                if (bus.s_axi_BUS_A_BREADY) wstate_d = WIDLE;
            end
            default: wstate_d = WIDLE;
        endcase
    end

    // Read data mux, sampled only on the AR handshake (pre-write values)
    always_comb begin
        rd_val    = '0;
        rd_mapped = (ridx < NREG);
        if (ridx == IDX_W'(0))
            rd_val[7:0] = {auto_q, 3'b000, ready_q, ap_idle, done_q, start_q};
        else if (ridx == IDX_W'(1))
            rd_val[0] = gie_q;
        else if (ridx == IDX_W'(2))
            rd_val[1:0] = ier_q;
        else if (ridx == IDX_W'(3))
            rd_val[1:0] = isr_q;
        for (int i = 0; i < N_ARGS; i++) begin
            if (ridx == IDX_W'(4 + i)) rd_val = arg_q[i];
        end
    end

    // Read channel FSM
    always_comb begin
        rstate_d                = rstate_q;
        rdata_d                 = rdata_q;
        rresp_d                 = rresp_q;
        ar_hs                   = 1'b0;
        bus.s_axi_BUS_A_ARREADY = 1'b0;
        bus.s_axi_BUS_A_RVALID  = 1'b0;
        case (rstate_q)
            RIDLE: begin
                bus.s_axi_BUS_A_ARREADY = 1'b1;
                if (bus.s_axi_BUS_A_ARVALID) begin
                    ar_hs    = 1'b1;
                    rdata_d  = rd_val;
                    rresp_d  = rd_mapped ? RESP_OKAY : RESP_SLVERR;
                    rstate_d = RDATA;
                end
            end
            RDATA: begin
                bus.s_axi_BUS_A_RVALID = 1'b1;
                if (bus.s_axi_BUS_A_RREADY) rstate_d = RIDLE;
            end
            default: rstate_d = RIDLE;
        endcase
    end

    // Register file and core handshake next state
    always_comb begin
        logic wr_ctrl;
        logic [1:0] toggle;
        wr_ctrl = w_commit && (widx == IDX_W'(0));
        toggle  = '0;
        start_d = start_q;
        auto_d  = auto_q;
        gie_d   = gie_q;
        ier_d   = ier_q;

        if (wr_ctrl && wmask[7]) auto_d = bus.s_axi_BUS_A_WDATA[7];
        if (w_commit && widx == IDX_W'(1) && wmask[0]) gie_d = bus.s_axi_BUS_A_WDATA[0];
        if (w_commit && widx == IDX_W'(2)) begin
            if (wmask[0]) ier_d[0] = bus.s_axi_BUS_A_WDATA[0];
            if (wmask[1]) ier_d[1] = bus.s_axi_BUS_A_WDATA[1];
        end
        if (w_commit && widx == IDX_W'(3)) toggle = wnew[1:0];

        // Later assignments win: a CTRL write of 1 overrides a same-cycle clear.
        if (ap_ready && !auto_q) start_d = 1'b0;
        if (ap_done && auto_q)   start_d = 1'b1;
        if (wr_ctrl && wnew[0])  start_d = 1'b1;

        // Clear-on-read first so a coincident event keeps the bit set.
        done_d  = (ar_hs && ridx == IDX_W'(0)) ? 1'b0 : done_q;
        ready_d = (ar_hs && ridx == IDX_W'(0)) ? 1'b0 : ready_q;
        if (ap_done)  done_d  = 1'b1;
        if (ap_ready) ready_d = 1'b1;

        isr_d = (isr_q ^ toggle) | ({ap_ready, ap_done} & ier_q);
        irq_d = gie_q & |(isr_q & ier_q);

        for (int i = 0; i < N_ARGS; i++) begin
            arg_d[i] = arg_q[i];
            if (w_commit && widx == IDX_W'(4 + i))
                arg_d[i] = (arg_q[i] & ~wmask) | wnew;
        end
    end

    always_ff @(posedge s_axi_BUS_A_ACLK or negedge s_axi_BUS_A_ARESETN) begin
        if (!s_axi_BUS_A_ARESETN) begin
            wstate_q <= WIDLE;
            rstate_q <= RIDLE;
            waddr_q  <= '0;
            bresp_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            auto_q   <= 1'b0;
            gie_q    <= 1'b0;
            ier_q    <= '0;
            isr_q    <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < N_ARGS; i++) arg_q[i] <= '0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            waddr_q  <= waddr_d;
            bresp_q  <= bresp_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            start_q  <= start_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            auto_q   <= auto_d;
            gie_q    <= gie_d;
            ier_q    <= ier_d;
            isr_q    <= isr_d;
            irq_q    <= irq_d;
            for (int i = 0; i < N_ARGS; i++) arg_q[i] <= arg_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N_ARGS; i++) args[i*DW +: DW] = arg_q[i];
    end

    assign bus.s_axi_BUS_A_BRESP = bresp_q;
    assign bus.s_axi_BUS_A_RDATA = rdata_q;
    assign bus.s_axi_BUS_A_RRESP = rresp_q;
    assign ap_start              = start_q;
    assign interrupt             = irq_q;

endmodule
